max_operand_feeder: RTL and testbench



---
 rtl/max_operand_feeder.sv | 110 +++++++++++
 tb/tb_max_operand_feeder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_operand_feeder.sv
// Upstream feeder for the pipelined max stage. It pairs stream bytes into A/B, strobes max_rdy, and returns the result.
// Optional MAX_OPERAND_FEEDER_TIE_FLAG_EN adds the out_tie output, which flags an A==B pair.
module max_operand_feeder #(
  parameter int data_width  = 8,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [data_width-1:0]  in_data,
  output logic                   in_ready,
  output logic                   max_rdy,
  output logic [data_width-1:0]  A,
  output logic [data_width-1:0]  B,
  input  logic [data_width-1:0]  result,
  output logic                   out_valid,
  output logic [data_width-1:0]  out_data,
  input  logic                   out_ready,
  output logic [count_width-1:0] pair_count
`ifdef MAX_OPERAND_FEEDER_TIE_FLAG_EN
  ,
  output logic                   out_tie
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HAVE_A = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t                  state_reg, state_next;
  logic [data_width-1:0]   a_reg, b_reg, out_data_reg;
  logic [count_width-1:0]  pair_count_reg;
  logic                    in_xfer, out_xfer;

  // Both strobes decode the registered state only, so they are glitch-free and never follow an input.
  assign in_ready   = !rst && ((state_reg == IDLE) || (state_reg == HAVE_A));
  assign max_rdy    = (state_reg == ISSUE);
  assign out_valid  = (state_reg == OUT);
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;

  assign A          = a_reg;
  assign B          = b_reg;
  assign out_data   = out_data_reg;
  assign pair_count = pair_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_xfer) state_next = HAVE_A;
      HAVE_A:  if (in_xfer) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg          <= '0;
      b_reg          <= '0;
      out_data_reg   <= '0;
      pair_count_reg <= '0;
    end else begin
      if (in_xfer && (state_reg == IDLE)) begin
        a_reg <= in_data;
      end
      if (in_xfer && (state_reg == HAVE_A)) begin
        b_reg <= in_data;
      end
      // The max stage registered on the ISSUE edge, so its result is settled throughout WAIT.
      if (state_reg == WAIT) begin
        out_data_reg <= result;
      end
      if (out_xfer) begin
        pair_count_reg <= pair_count_reg + count_width'(1);
      end
    end
  end

`ifdef MAX_OPERAND_FEEDER_TIE_FLAG_EN
  logic out_tie_reg;

  assign out_tie = out_tie_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_tie_reg <= 1'b0;
    end else if (state_reg == WAIT) begin
      out_tie_reg <= (a_reg == b_reg);
    end else if (out_xfer) begin
      out_tie_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_max_operand_feeder.sv
// Directed bench for max_operand_feeder. A queue scoreboard holds the expected results, and a behavioural max stage feeds the result input.
// A second instance with a 4-bit counter runs in lockstep and exercises the pair_count wrap.
module tb_max_operand_feeder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        in_ready, max_rdy, out_valid;
  logic [7:0]  a_o, b_o, result, out_data;
  logic [15:0] pair_count;
  logic        out_tie;

  logic        w_in_ready, w_max_rdy, w_out_valid;
  logic [7:0]  w_a, w_b, w_result, w_out_data;
  logic [3:0]  w_pair_count;
  logic        w_out_tie;

  typedef struct packed {
    logic [7:0] data;
    logic       tie;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          mr_count = 0;
  int          exp_count = 0;

  max_operand_feeder #(.data_width(8), .count_width(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .max_rdy(max_rdy), .A(a_o), .B(b_o), .result(result), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .pair_count(pair_count)
`ifdef MAX_OPERAND_FEEDER_TIE_FLAG_EN
    , .out_tie(out_tie)
`endif
  );

  max_operand_feeder #(.data_width(8), .count_width(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(w_in_ready),
    .max_rdy(w_max_rdy), .A(w_a), .B(w_b), .result(w_result), .out_valid(w_out_valid),
    .out_data(w_out_data), .out_ready(out_ready), .pair_count(w_pair_count)
`ifdef MAX_OPERAND_FEEDER_TIE_FLAG_EN
    , .out_tie(w_out_tie)
`endif
  );

`ifndef MAX_OPERAND_FEEDER_TIE_FLAG_EN
  assign out_tie   = 1'b0;
  assign w_out_tie = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] max_of(input logic [7:0] a, input logic [7:0] b);
    if (a == b) return 8'h00;
    return (a > b) ? a : b;
  endfunction

  // Behavioural max stage: it registers on the max_rdy edge and returns 0 for equal operands.
  always @(posedge clk) begin
    if (max_rdy) result <= max_of(a_o, b_o);
    if (w_max_rdy) w_result <= max_of(w_a, w_b);
    if (max_rdy) mr_count <= mr_count + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge. Holds in_valid until the byte is taken.
  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 16'(in_ready), 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.data = max_of(a, b);
    e.tie  = (a == b);
    exp_q.push_back(e);
    send_byte(a);
    send_byte(b);
  endtask

  task automatic recv();
    int   n = 0;
    exp_t e;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", 16'(out_valid), 16'd1);
    check("scoreboard_nonempty", 16'(exp_q.size() > 0), 16'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_data", 16'(out_data), 16'(e.data));
`ifdef MAX_OPERAND_FEEDER_TIE_FLAG_EN
      check("out_tie", 16'(out_tie), 16'(e.tie));
`endif
    end
    @(negedge clk);
    exp_count++;
    check("out_valid_drop", 16'(out_valid), 16'd0);
    check("pair_count", pair_count, 16'(exp_count));
    check("pair_count_w", 16'(w_pair_count), 16'(exp_count[3:0]));
    $display("pair %0d done: out_data=0x%0h pair_count=%0d", exp_count, out_data, pair_count);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [7:0] held;
    int         n;
    int         mr_snap;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #3;
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_max_rdy", 16'(max_rdy), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_regs", 16'({a_o, b_o} | {out_data, 8'h00}), 16'd0);
    check("rst_pair_count", pair_count, 16'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check("idle_in_ready", 16'(in_ready), 16'd1);

    // Reset mid-pair: asynchronous reset from HAVE_A
    @(negedge clk);
    send_byte(8'h11);
    check("havea_A", 16'(a_o), 16'h11);
    #2 rst = 1'b1;
    #1;
    check("midrst_A", 16'(a_o), 16'h00);
    check("midrst_B", 16'(b_o), 16'h00);
    check("midrst_in_ready", 16'(in_ready), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_data", 16'(out_data), 16'h00);
    check("midrst_pair_count", pair_count, 16'd0);
    check("midrst_idle", 16'(in_ready), 16'd1);
    check("midrst_no_max_rdy", 16'(mr_count), 16'd0);
    @(negedge clk);

    // Basic pair
    out_ready = 1'b1;
    send_pair(8'h12, 8'h34);
    check("basic_max_rdy", 16'(max_rdy), 16'd1);
    check("basic_A", 16'(a_o), 16'h12);
    check("basic_B", 16'(b_o), 16'h34);
    check("basic_issue_in_ready", 16'(in_ready), 16'd0);
    @(negedge clk);
    check("basic_max_rdy_drop", 16'(max_rdy), 16'd0);
    check("basic_wait_out_valid", 16'(out_valid), 16'd0);
    @(negedge clk);
    check("basic_out_valid_t2", 16'(out_valid), 16'd1);
    recv();
    check("basic_one_max_rdy", 16'(mr_count), 16'd1);

    // Equal operands, then a near pair
    send_pair(8'h55, 8'h55);
    recv();
    send_pair(8'h00, 8'h01);
    recv();

    // Downstream backpressure with in_valid held high
    out_ready = 1'b0;
    send_pair(8'h20, 8'h30);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid", 16'(out_valid), 16'd1);
    held = out_data;
    mr_snap = mr_count;
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_data", 16'(out_data), 16'(held));
      check("bp_in_ready", 16'(in_ready), 16'd0);
      check("bp_out_valid_hold", 16'(out_valid), 16'd1);
    end
    check("bp_no_second_max_rdy", 16'(mr_count), 16'(mr_snap));
    in_valid = 1'b0;
    recv();
    send_pair(8'h40, 8'h07);
    recv();

    // Upstream gaps: valid 1,0,0,1
    exp_q.push_back('{data: 8'hF0, tie: 1'b0});
    send_byte(8'hF0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("gap_no_max_rdy", 16'(max_rdy), 16'd0);
      check("gap_A", 16'(a_o), 16'hF0);
    end
    send_byte(8'h0F);
    check("gap_max_rdy", 16'(max_rdy), 16'd1);
    check("gap_B", 16'(b_o), 16'h0F);
    recv();

    // Random pairs up to the wrap of the 4-bit counter
    while (exp_count < 15) begin
      ra = 8'($urandom_range(0, 255));
      rb = (exp_count % 4 == 0) ? ra : 8'($urandom_range(0, 255));
      send_pair(ra, rb);
      recv();
    end
    check("wrap_pre", 16'(w_pair_count), 16'hF);
    send_pair(8'h9A, 8'hA9);
    recv();
    check("wrap_post", 16'(w_pair_count), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
